hax_call_dispatcher: RTL and testbench

Request-side controller for the elevator car. It collects hall and car button calls into pending-call bitmaps and picks the next floor with a collective up/down sweep. It drives the car's `direction`/`target`/`pressed` request interface one target at a time. It watches the car's `current_floor`/`door_state`/`elevator_direction` to detect acknowledgement and arrival, then clears served calls and holds a door dwell before issuing again.

---
 rtl/hax_call_dispatcher_pkg.sv | 38 +++
 rtl/hax_call_dispatcher_if.sv | 35 +++
 rtl/hax_call_dispatcher_picker.sv | 68 ++++++
 rtl/hax_call_dispatcher.sv | 166 ++++++++++++++++
 tb/tb_hax_call_dispatcher.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hax_call_dispatcher_pkg.sv
// Shared types for the elevator call dispatcher.
//   floor_t          : floor number, one bit wider than 8 floors need so that
//                      out-of-range floor numbers can be expressed and rejected
//   direction_t      : IDLE / UP / DOWN
//   door_t           : car door state
//   dispatch_state_t : dispatcher FSM states
package hax_call_dispatcher_pkg;

  typedef logic [3:0] floor_t;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } direction_t;

  typedef enum logic [1:0] {
    DOOR_CLOSED  = 2'd0,
    DOOR_OPENING = 2'd1,
    DOOR_OPEN    = 2'd2,
    DOOR_CLOSING = 2'd3
  } door_t;

  typedef enum logic [1:0] {
    D_IDLE   = 2'd0,
    D_ACK    = 2'd1,
    D_TRAVEL = 2'd2,
    D_DWELL  = 2'd3
  } dispatch_state_t;

  localparam int NUM_FLOORS_DEFAULT = 8;

  // Travel direction of a request: UP only when strictly above the car.
  function automatic direction_t dir_toward(floor_t to, floor_t from);
    return (to > from) ? DIR_UP : DIR_DOWN;
  endfunction

endpackage

// File: rtl/hax_call_dispatcher_if.sv
// Button-event / car-request bundle of the call dispatcher.
//   call_valid/call_floor/call_dir         : button events
//   current_floor/door_state/elev_direction: car status
//   target/direction/pressed               : request to the car
//   pending/busy                           : dispatcher status
// slave = dispatcher side, master = button panel + car side.
interface hax_call_dispatcher_if
  import hax_call_dispatcher_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT
);
  logic                  call_valid;
  floor_t                call_floor;
  direction_t            call_dir;
  floor_t                current_floor;
  door_t                 door_state;
  direction_t            elevator_direction;
  floor_t                target;
  direction_t            direction;
  logic                  pressed;
  logic [NUM_FLOORS-1:0] pending;
  logic                  busy;

  modport master (
    output call_valid, call_floor, call_dir,
    output current_floor, door_state, elevator_direction,
    input  target, direction, pressed, pending, busy
  );

  modport slave (
    input  call_valid, call_floor, call_dir,
    input  current_floor, door_state, elevator_direction,
    output target, direction, pressed, pending, busy
  );
endinterface

// File: rtl/hax_call_dispatcher_picker.sv
// Combinational collective-sweep floor selector.
//   pending       : OR of all call bitmaps
//   current_floor : car position
//   sweep_dir     : current sweep direction (UP/DOWN)
//   pick_valid    : a pending floor exists away from current_floor
//   pick_floor    : nearest pending floor beyond the car in sweep_dir, or,
//                   if none, nearest in the opposite direction
//   pick_dir      : UP if pick_floor is above the car, else DOWN
//   next_sweep    : sweep_dir, flipped when the pick had to reverse
module hax_call_picker
  import hax_call_dispatcher_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  floor_t                current_floor,
  input  direction_t            sweep_dir,
  output logic                  pick_valid,
  output floor_t                pick_floor,
  output direction_t            pick_dir,
  output direction_t            next_sweep
);

  logic   up_found, dn_found;
  floor_t up_floor, dn_floor;

  always_comb begin
    up_found = 1'b0;
    up_floor = '0;
    dn_found = 1'b0;
    dn_floor = '0;
    // Scan downward so the last hit above the car is the closest one.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(current_floor))) begin
        up_found = 1'b1;
        up_floor = floor_t'(i);
      end
    end
    // Scan upward so the last hit below the car is the closest one.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(current_floor))) begin
        dn_found = 1'b1;
        dn_floor = floor_t'(i);
      end
    end
  end

  always_comb begin
    pick_valid = 1'b1;
    pick_floor = '0;
    next_sweep = sweep_dir;
    if (sweep_dir == DIR_DOWN) begin
      if (dn_found)      pick_floor = dn_floor;
      else if (up_found) begin
        pick_floor = up_floor;
        next_sweep = DIR_UP;
      end else           pick_valid = 1'b0;
    end else begin
      if (up_found)      pick_floor = up_floor;
      else if (dn_found) begin
        pick_floor = dn_floor;
        next_sweep = DIR_DOWN;
      end else           pick_valid = 1'b0;
    end
    pick_dir = dir_toward(pick_floor, current_floor);
  end

endmodule

// File: rtl/hax_call_dispatcher.sv
// Elevator request-side controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hax_call_dispatcher_if.slave (button events, car status in;
//                target/direction/pressed request, pending, busy out)
// Holds the hall-up / hall-down / car-call bitmaps, issues one target at a
// time to the car, waits for the car to acknowledge (re-issuing after
// ACK_LIMIT cycles of silence), clears served calls on arrival and holds a
// door dwell of DWELL_CYCLES+1 cycles before the next issue.
module hax_call_dispatcher
  import hax_call_dispatcher_pkg::*;
#(
  parameter int          NUM_FLOORS   = NUM_FLOORS_DEFAULT,
  parameter logic [25:0] DWELL_CYCLES = 26'd50000000,
  parameter int          ACK_LIMIT    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  hax_call_dispatcher_if.slave bus
);

  localparam logic [7:0] ACK_LAST = 8'(ACK_LIMIT - 1);

  dispatch_state_t       state_q, state_d;
  logic [NUM_FLOORS-1:0] hall_up_q, hall_dn_q, car_q;
  logic [NUM_FLOORS-1:0] pend, call_hot, cf_hot, tgt_hot;
  logic [NUM_FLOORS-1:0] set_up, set_dn, set_car, clr_vec;
  floor_t                target_q, target_d;
  direction_t            dir_q, dir_d, sweep_q, sweep_d;
  logic                  pressed_q, pressed_d;
  logic [7:0]            ack_q, ack_d;
  logic [25:0]           dwell_q, dwell_d;
  logic                  do_issue, door_open, call_here;

  logic       pick_valid;
  floor_t     pick_floor;
  direction_t pick_dir, next_sweep;

  assign pend = hall_up_q | hall_dn_q | car_q;

  hax_call_picker #(.NUM_FLOORS(NUM_FLOORS)) u_picker (
    .pending      (pend),
    .current_floor(bus.current_floor),
    .sweep_dir    (sweep_q),
    .pick_valid   (pick_valid),
    .pick_floor   (pick_floor),
    .pick_dir     (pick_dir),
    .next_sweep   (next_sweep)
  );

  // One-hot decodes; out-of-range floors decode to all zeros, so calls there
  // fall away without a separate range check.
  always_comb begin
    call_hot = '0;
    cf_hot   = '0;
    tgt_hot  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      call_hot[i] = bus.call_valid && (int'(bus.call_floor) == i);
      cf_hot[i]   = (int'(bus.current_floor) == i);
      tgt_hot[i]  = (int'(target_q) == i);
    end
  end

  assign set_up    = (bus.call_dir == DIR_UP)   ? call_hot : '0;
  assign set_dn    = (bus.call_dir == DIR_DOWN) ? call_hot : '0;
  assign set_car   = (bus.call_dir == DIR_IDLE) ? call_hot : '0;
  assign door_open = (bus.door_state == DOOR_OPEN);
  assign call_here = |(call_hot & cf_hot);

  always_comb begin
    state_d   = state_q;
    pressed_d = 1'b0;
    target_d  = target_q;
    dir_d     = dir_q;
    sweep_d   = sweep_q;
    ack_d     = ack_q;
    dwell_d   = dwell_q;
    clr_vec   = '0;
    do_issue  = 1'b0;
    unique case (state_q)
      D_IDLE: begin
        // A call at the car's own floor is only served once the door is open;
        // with the door shut it waits while other floors are still issued.
        if (|(pend & cf_hot) && door_open) begin
          clr_vec = cf_hot;
          dwell_d = '0;
          state_d = D_DWELL;
        end else if (pick_valid) begin
          do_issue = 1'b1;
        end
      end
      D_ACK: begin
        if (bus.elevator_direction == dir_q) begin
          state_d = D_TRAVEL;
        end else if (ack_q == ACK_LAST) begin
          if (pick_valid) do_issue = 1'b1;
          else            state_d  = D_IDLE;
        end else begin
          ack_d = ack_q + 8'd1;
        end
      end
      D_TRAVEL: begin
        if ((bus.current_floor == target_q) && door_open) begin
          clr_vec = tgt_hot;
          dwell_d = '0;
          state_d = D_DWELL;
        end
      end
      D_DWELL: begin
        if (call_here) begin
          // Serve the late call in place and keep the door open longer.
          clr_vec = cf_hot;
          dwell_d = '0;
        end else if (dwell_q == DWELL_CYCLES) begin
          if (pick_valid) do_issue = 1'b1;
          else            state_d  = D_IDLE;
        end else begin
          dwell_d = dwell_q + 26'd1;
        end
      end
      default: state_d = D_IDLE;
    endcase

    if (do_issue) begin
      target_d  = pick_floor;
      dir_d     = pick_dir;
      sweep_d   = next_sweep;
      pressed_d = 1'b1;
      ack_d     = '0;
      state_d   = D_ACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= D_IDLE;
      hall_up_q <= '0;
      hall_dn_q <= '0;
      car_q     <= '0;
      target_q  <= '0;
      dir_q     <= DIR_IDLE;
      sweep_q   <= DIR_UP;
      pressed_q <= 1'b0;
      ack_q     <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      // Clear wins over a same-cycle set at the same floor.
      hall_up_q <= (hall_up_q | set_up)  & ~clr_vec;
      hall_dn_q <= (hall_dn_q | set_dn)  & ~clr_vec;
      car_q     <= (car_q     | set_car) & ~clr_vec;
      target_q  <= target_d;
      dir_q     <= dir_d;
      sweep_q   <= sweep_d;
      pressed_q <= pressed_d;
      ack_q     <= ack_d;
      dwell_q   <= dwell_d;
    end
  end

  assign bus.target    = target_q;
  assign bus.direction = dir_q;
  assign bus.pressed   = pressed_q;
  assign bus.pending   = pend;
  assign bus.busy      = (state_q != D_IDLE);

endmodule

// File: tb/tb_hax_call_dispatcher.sv
// Self-checking bench for hax_call_dispatcher with a behavioural car model.
module tb_hax_call_dispatcher;
  import hax_call_dispatcher_pkg::*;

  localparam int NF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hax_call_dispatcher_if #(.NUM_FLOORS(NF)) bus();

  hax_call_dispatcher #(
    .NUM_FLOORS  (NF),
    .DWELL_CYCLES(26'd10),
    .ACK_LIMIT   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- behavioural car ----------------
  floor_t     car_floor, car_goal, car_start;
  door_t      car_door;
  direction_t car_edir;
  logic       car_moving, car_load, car_ignore;
  int         car_tmr;

  assign bus.current_floor      = car_floor;
  assign bus.door_state         = car_door;
  assign bus.elevator_direction = car_edir;

  // Acks on the edge sampling pressed, moves one floor every 2 cycles, opens
  // the door and goes direction-idle one cycle after reaching the goal.
  always @(posedge clk) begin
    if (car_load) begin
      car_floor  <= car_start;
      car_door   <= DOOR_CLOSED;
      car_edir   <= DIR_IDLE;
      car_moving <= 1'b0;
      car_goal   <= car_start;
      car_tmr    <= 0;
    end else if (bus.pressed && !car_ignore) begin
      car_goal   <= bus.target;
      car_edir   <= bus.direction;
      car_door   <= DOOR_CLOSED;
      car_moving <= 1'b1;
      car_tmr    <= 0;
    end else if (car_moving) begin
      if (car_floor == car_goal) begin
        car_door   <= DOOR_OPEN;
        car_edir   <= DIR_IDLE;
        car_moving <= 1'b0;
      end else if (car_tmr == 1) begin
        car_tmr   <= 0;
        car_floor <= (car_floor < car_goal) ? car_floor + 4'd1 : car_floor - 4'd1;
      end else begin
        car_tmr <= car_tmr + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int vecs = 0;
  int miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int start);
    rst_n          = 1'b0;
    car_start      = floor_t'(start);
    car_load       = 1'b1;
    bus.call_valid = 1'b0;
    bus.call_floor = '0;
    bus.call_dir   = DIR_IDLE;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    car_load = 1'b0;
  endtask

  // Drive one event for the next edge; returns at the negedge after it.
  task automatic call(input int f, input direction_t d);
    bus.call_valid = 1'b1;
    bus.call_floor = floor_t'(f);
    bus.call_dir   = d;
    @(negedge clk);
    bus.call_valid = 1'b0;
  endtask

  task automatic wait_arrive(input string nm, input int f, output bit ok);
    int n = 0;
    while (!(int'(car_floor) == f && car_door == DOOR_OPEN) && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 300);
    if (!ok) chk(nm, 0, 1);
  endtask

  task automatic wait_press(input string nm, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      n++;
      ok = bus.pressed;
    end
    if (!ok) chk(nm, 0, 1);
  endtask

  // Reference pick: walk outward from the car floor.
  function automatic bit has(input logic [NF-1:0] p, input int f);
    return ((p >> f) & 8'd1) != 8'd0;
  endfunction

  function automatic void pick_ref(input logic [NF-1:0] p, input int cf,
                                   input direction_t sw, output bit v,
                                   output int t, output direction_t d,
                                   output direction_t ns);
    int above = -1;
    int below = -1;
    for (int f = cf + 1; f < NF; f++) if (above < 0 && has(p, f)) above = f;
    for (int f = cf - 1; f >= 0; f--) if (below < 0 && has(p, f)) below = f;
    v = 1'b1; t = 0; ns = sw;
    if (sw == DIR_UP) begin
      if (above >= 0)      t = above;
      else if (below >= 0) begin t = below; ns = DIR_DOWN; end
      else                 v = 1'b0;
    end else begin
      if (below >= 0)      t = below;
      else if (above >= 0) begin t = above; ns = DIR_UP; end
      else                 v = 1'b0;
    end
    d = (t > cf) ? DIR_UP : DIR_DOWN;
  endfunction

  // ---------------- single-call vector table ----------------
  typedef struct {
    int         start;
    int         cf;
    direction_t cd;
    int         exp_pend;
    int         exp_press;
    int         exp_tgt;
    direction_t exp_dir;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok, saw, ev;
    int n, et, f, pf, mtgt;
    bit pv, mtrav;
    direction_t ed, ens, msweep;
    logic [NF-1:0] mpend;

    car_ignore = 1'b0;
    tbl[0] = '{0, 3, DIR_IDLE, 8'h08, 1, 3, DIR_UP};
    tbl[1] = '{0, 7, DIR_UP,   8'h80, 1, 7, DIR_UP};
    tbl[2] = '{5, 2, DIR_DOWN, 8'h04, 1, 2, DIR_DOWN};
    tbl[3] = '{7, 0, DIR_UP,   8'h01, 1, 0, DIR_DOWN};
    tbl[4] = '{0, 8, DIR_IDLE, 8'h00, 0, 0, DIR_IDLE};
    tbl[5] = '{3, 15, DIR_DOWN, 8'h00, 0, 0, DIR_IDLE};
    tbl[6] = '{4, 6, DIR_DOWN, 8'h40, 1, 6, DIR_UP};

    // Reset state
    do_reset(0);
    chk("rst_pressed", bus.pressed, 0);
    chk("rst_target", bus.target, 0);
    chk("rst_direction", bus.direction, DIR_IDLE);
    chk("rst_pending", bus.pending, 0);
    chk("rst_busy", bus.busy, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset(tbl[i].start);
      call(tbl[i].cf, tbl[i].cd);
      chk($sformatf("tbl%0d_pending", i), bus.pending, tbl[i].exp_pend);
      chk($sformatf("tbl%0d_early_press", i), bus.pressed, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_pressed", i), bus.pressed, tbl[i].exp_press);
      chk($sformatf("tbl%0d_target", i), bus.target, tbl[i].exp_tgt);
      chk($sformatf("tbl%0d_direction", i), bus.direction, tbl[i].exp_dir);
    end

    // Car call 3: one-cycle strobe, arrival clear, idle after the dwell
    do_reset(0);
    call(3, DIR_IDLE);
    chk("t1_pending", bus.pending, 8'h08);
    @(negedge clk);
    chk("t1_pressed", bus.pressed, 1);
    chk("t1_target", bus.target, 3);
    chk("t1_dir", bus.direction, DIR_UP);
    @(negedge clk);
    chk("t1_press_once", bus.pressed, 0);
    chk("t1_target_held", bus.target, 3);
    wait_arrive("t1_arrive_timeout", 3, ok);
    if (ok) begin
      chk("t1_pend_before_clear", bus.pending, 8'h08);
      @(negedge clk);
      chk("t1_pend_after_clear", bus.pending, 0);
      repeat (10) @(negedge clk);
      chk("t1_busy_in_dwell", bus.busy, 1);
      @(negedge clk);
      chk("t1_idle_after_dwell", bus.busy, 0);
    end

    // Sweep: 2->5, hall 1 UP and 6 DOWN mid-travel -> 6 UP then 1 DOWN
    do_reset(2);
    call(5, DIR_IDLE);
    @(negedge clk);
    chk("sw_first_press", bus.pressed, 1);
    chk("sw_first_target", bus.target, 5);
    repeat (4) @(negedge clk);
    call(1, DIR_UP);
    call(6, DIR_DOWN);
    chk("sw_target_kept", bus.target, 5);
    wait_press("sw_second_timeout", ok);
    if (ok) begin
      chk("sw_second_target", bus.target, 6);
      chk("sw_second_dir", bus.direction, DIR_UP);
      wait_press("sw_third_timeout", ok);
      if (ok) begin
        chk("sw_third_target", bus.target, 1);
        chk("sw_third_dir", bus.direction, DIR_DOWN);
      end
    end

    // Car call at the car's floor during dwell restarts the dwell
    do_reset(0);
    call(2, DIR_IDLE);
    wait_arrive("dw_arrive_timeout", 2, ok);
    if (ok) begin
      repeat (4) @(negedge clk);
      call(2, DIR_IDLE);
      chk("dw_pending_cleared", bus.pending, 0);
      saw = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (bus.pressed) saw = 1'b1;
      end
      chk("dw_busy_restarted", bus.busy, 1);
      @(negedge clk);
      chk("dw_idle_after_restart", bus.busy, 0);
      chk("dw_no_press", saw, 0);
    end

    // Call at 5 on the same edge as the arrival clear at 5
    do_reset(0);
    call(5, DIR_IDLE);
    wait_arrive("sc_arrive_timeout", 5, ok);
    if (ok) begin
      call(5, DIR_UP);
      chk("sc_clear_wins", bus.pending, 0);
      @(negedge clk);
      chk("sc_stays_clear", bus.pending, 0);
    end

    // Car ignores requests: re-issue every ACK_LIMIT cycles, same target
    car_ignore = 1'b1;
    do_reset(0);
    call(4, DIR_IDLE);
    @(negedge clk);
    chk("ack_first_press", bus.pressed, 1);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.pressed && n < 20);
      chk($sformatf("ack_gap%0d", r), n, 4);
      chk($sformatf("ack_target%0d", r), bus.target, 4);
    end
    car_ignore = 1'b0;

    // Asynchronous reset mid-travel
    do_reset(0);
    call(6, DIR_IDLE);
    repeat (7) @(negedge clk);
    chk("ar_busy_before", bus.busy, 1);
    #2;
    rst_n    = 1'b0;
    car_load = 1'b1;
    #1;
    chk("ar_pressed", bus.pressed, 0);
    chk("ar_target", bus.target, 0);
    chk("ar_direction", bus.direction, DIR_IDLE);
    chk("ar_pending", bus.pending, 0);
    chk("ar_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    chk("ar_target_hold", bus.target, 0);
    chk("ar_busy_hold", bus.busy, 0);
    rst_n    = 1'b1;
    car_load = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.pressed) saw = 1'b1;
    end
    chk("ar_no_spurious_press", saw, 0);

    // Randomized calls against the reference pick/pending model
    do_reset(0);
    msweep = DIR_UP;
    mpend  = '0;
    mtrav  = 1'b0;
    mtgt   = 0;
    pv     = 1'b0;
    pf     = 0;
    for (int j = 0; j < 4000; j++) begin
      @(negedge clk);
      bus.call_valid = 1'b0;
      if (bus.pressed) begin
        pick_ref(mpend, int'(car_floor), msweep, ev, et, ed, ens);
        chk("rnd_press_expected", 1, int'(ev));
        chk("rnd_target", bus.target, et);
        chk("rnd_dir", bus.direction, ed);
        mtgt   = et;
        msweep = ens;
        mtrav  = 1'b1;
      end
      if (pv) mpend = mpend | (8'd1 << pf);
      pv = 1'b0;
      chk("rnd_pending", bus.pending, int'(mpend));
      if (mtrav && int'(car_floor) == mtgt && car_door == DOOR_OPEN) begin
        mpend = mpend & ~(8'd1 << mtgt);
        mtrav = 1'b0;
      end
      if (j < 2500 && $urandom_range(0, 7) == 0) begin
        f = int'($urandom_range(0, 9));
        if (f != int'(car_floor)) begin
          bus.call_valid = 1'b1;
          bus.call_floor = floor_t'(f);
          case ($urandom_range(0, 2))
            0:       bus.call_dir = DIR_UP;
            1:       bus.call_dir = DIR_DOWN;
            default: bus.call_dir = DIR_IDLE;
          endcase
          if (f < NF) begin
            pv = 1'b1;
            pf = f;
          end
        end
      end
    end
    chk("rnd_drained_busy", bus.busy, 0);
    chk("rnd_drained_pending", bus.pending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
